// File: rtl/acc_pipe_core.sv
// 3-stage (IF/ID/EX) accumulator processor with Hack-style ALU, program-load port and store->load forwarding.
// Optional PERF_CNT_EN adds the cyc_cnt/ret_cnt performance counters.
module acc_pipe_core #(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 10,
  parameter int unsigned IM_DEPTH = 401,
  parameter int unsigned DM_DEPTH = 623
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          start,
  output logic          halted,
  input  logic          ld_en,
  input  logic          ld_sel,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] dm_rd_addr,
  output logic [DW-1:0] dm_rd_data,
  output logic [DW-1:0] acc,
  output logic [AW-1:0] pc,
  output logic [1:0]    flags
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]   cyc_cnt,
  output logic [31:0]   ret_cnt
`endif
);

  localparam int unsigned IW   = 1 + 5 + AW;
  localparam int unsigned IMAW = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
  localparam int unsigned DMAW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  typedef enum logic [4:0] {
    OP_LDA = 5'h12,
    OP_STA = 5'h13,
    OP_JMP = 5'h14,
    OP_JZ  = 5'h15,
    OP_JN  = 5'h16,
    OP_NOP = 5'h17,
    OP_HLT = 5'h1F
  } op_t;

  localparam logic [IW-1:0] NOP_INSTR = {1'b0, OP_NOP, {AW{1'b0}}};

  function automatic logic in_im(input logic [AW-1:0] a);
    return 32'(a) < IM_DEPTH;
  endfunction

  function automatic logic in_dm(input logic [AW-1:0] a);
    return 32'(a) < DM_DEPTH;
  endfunction

  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] p);
    return (32'(p) == IM_DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [5:0] alu_cb(input logic [4:0] op);
    case (op)
      5'h00:   return 6'b101010;
      5'h01:   return 6'b111111;
      5'h02:   return 6'b111010;
      5'h03:   return 6'b001100;
      5'h04:   return 6'b110000;
      5'h05:   return 6'b001101;
      5'h06:   return 6'b110001;
      5'h07:   return 6'b001111;
      5'h08:   return 6'b110011;
      5'h09:   return 6'b011111;
      5'h0A:   return 6'b110111;
      5'h0B:   return 6'b001110;
      5'h0C:   return 6'b110010;
      5'h0D:   return 6'b000010;
      5'h0E:   return 6'b010011;
      5'h0F:   return 6'b000111;
      5'h10:   return 6'b000000;
      5'h11:   return 6'b010101;
      5'h12:   return 6'b110000;
      default: return 6'b101010;
    endcase
  endfunction

  // cb = {zx, nx, zy, ny, f, no}
  function automatic logic [DW-1:0] alu(input logic [5:0] cb, input logic [DW-1:0] x_in,
                                        input logic [DW-1:0] y_in);
    logic [DW-1:0] x, y, r;
    x = cb[5] ? '0 : x_in;
    if (cb[4]) x = ~x;
    y = cb[3] ? '0 : y_in;
    if (cb[2]) y = ~y;
    r = cb[1] ? (x + y) : (x & y);
    if (cb[0]) r = ~r;
    return r;
  endfunction

  logic [IW-1:0] im [IM_DEPTH];
  logic [DW-1:0] dm [DM_DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          ifid_valid_q, ifid_valid_d;
  logic [IW-1:0] ifid_instr_q, ifid_instr_d;
  logic [AW-1:0] ifid_pc_q, ifid_pc_d;
  logic          idex_valid_q, idex_valid_d;
  logic [4:0]    idex_op_q, idex_op_d;
  logic [DW-1:0] idex_opnd_q, idex_opnd_d;
  logic [AW-1:0] idex_ea_q, idex_ea_d;
  logic [AW-1:0] idex_pc_q, idex_pc_d;

  logic [IW-1:0] fetch_instr;
  logic          id_ind;
  logic [4:0]    id_op;
  logic [AW-1:0] id_a, id_ptr, id_ea;
  logic [DW-1:0] id_m1, id_m2, id_opnd;
  logic          st_we, ex_taken, ex_hlt, ex_alu, ld_ok;

  assign ld_ok       = ld_en && (state_q != S_RUN);
  assign fetch_instr = in_im(pc_q) ? im[pc_q[IMAW-1:0]] : NOP_INSTR;

  assign id_ind = ifid_instr_q[IW-1];
  assign id_op  = ifid_instr_q[IW-2 -: 5];
  assign id_a   = ifid_instr_q[AW-1:0];

  // A STA retiring this cycle has not reached dm yet, so ID takes acc for a matching address
  assign st_we   = idex_valid_q && (idex_op_q == OP_STA) && in_dm(idex_ea_q);
  assign id_m1   = (st_we && idex_ea_q == id_a) ? acc_q
                 : (in_dm(id_a) ? dm[id_a[DMAW-1:0]] : '0);
  assign id_ptr  = id_m1[AW-1:0];
  assign id_m2   = (st_we && idex_ea_q == id_ptr) ? acc_q
                 : (in_dm(id_ptr) ? dm[id_ptr[DMAW-1:0]] : '0);
  assign id_opnd = id_ind ? id_m2 : id_m1;
  assign id_ea   = id_ind ? id_ptr : id_a;

  assign ex_alu   = idex_valid_q && (idex_op_q <= 5'h12);
  assign ex_hlt   = idex_valid_q && (idex_op_q == OP_HLT);
  assign ex_taken = idex_valid_q && ((idex_op_q == OP_JMP) ||
                                     (idex_op_q == OP_JZ && acc_q == '0) ||
                                     (idex_op_q == OP_JN && acc_q[DW-1]));

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    acc_d        = acc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    idex_valid_d = idex_valid_q;
    idex_op_d    = idex_op_q;
    idex_opnd_d  = idex_opnd_q;
    idex_ea_d    = idex_ea_q;
    idex_pc_d    = idex_pc_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d      = S_RUN;
          pc_d         = '0;
          ifid_valid_d = 1'b0;
          idex_valid_d = 1'b0;
        end
      end
      S_RUN: begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = fetch_instr;
        ifid_pc_d    = pc_q;
        pc_d         = pc_inc(pc_q);
        idex_valid_d = ifid_valid_q;
        idex_op_d    = id_op;
        idex_opnd_d  = id_opnd;
        idex_ea_d    = id_ea;
        idex_pc_d    = ifid_pc_q;
        if (ex_alu) acc_d = alu(alu_cb(idex_op_q), acc_q, idex_opnd_q);
        if (ex_hlt) begin
          state_d      = S_HALT;
          pc_d         = pc_inc(idex_pc_q);
          ifid_valid_d = 1'b0;
          idex_valid_d = 1'b0;
        end else if (ex_taken) begin
          pc_d         = idex_ea_q;
          ifid_valid_d = 1'b0;
          idex_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      acc_q        <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      idex_valid_q <= 1'b0;
      idex_op_q    <= '0;
      idex_opnd_q  <= '0;
      idex_ea_q    <= '0;
      idex_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      acc_q        <= acc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      idex_valid_q <= idex_valid_d;
      idex_op_q    <= idex_op_d;
      idex_opnd_q  <= idex_opnd_d;
      idex_ea_q    <= idex_ea_d;
      idex_pc_q    <= idex_pc_d;
    end
  end

  // Memories survive reset; load-port and STA writes are exclusive since one needs halted
  always_ff @(posedge clk1) begin
    if (ld_ok && !ld_sel && in_im(ld_addr)) im[ld_addr[IMAW-1:0]] <= ld_data[IW-1:0];
    if (ld_ok && ld_sel && in_dm(ld_addr)) dm[ld_addr[DMAW-1:0]] <= ld_data;
    else if (st_we)                        dm[idex_ea_q[DMAW-1:0]] <= acc_q;
  end

`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d, ret_cnt_q, ret_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (state_q != S_RUN) begin
      if (start) begin
        cyc_cnt_d = '0;
        ret_cnt_d = '0;
      end
    end else begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
      if (idex_valid_q) ret_cnt_d = ret_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

  assign halted     = (state_q != S_RUN);
  assign acc        = acc_q;
  assign pc         = pc_q;
  assign flags      = {acc_q[DW-1], acc_q == '0};
  assign dm_rd_data = in_dm(dm_rd_addr) ? dm[dm_rd_addr[DMAW-1:0]] : '0;

endmodule
